wb_regfile: RTL

//   Write-back stage plus architectural register file of the 5-stage MIPS pipeline.

---
 rtl/wb_regfile.sv | 105 ++++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file: picks the write-back value and commits it to the register file.
// Latency: write-back outputs and read ports are combinational (0 cycles); a write becomes state at the next rising edge.
// Backpressure: none; one write-back is accepted every cycle and a same-cycle write is bypassed to both read ports.
//
// Ports:
//   clk_i, rst_i                  clock; asynchronous active-high reset
//   regwrite_i, memtoreg_i        MEM/WB control bits
//   readdata_i, aluresult_i       write-back value candidates
//   rd_i                          write-back destination index
//   rs_addr_i / rs_data_o         read port A
//   rt_addr_i / rt_data_o         read port B
//   wb_data_o, wb_rd_o, wb_en_o   write-back bus to the forwarding unit
//   wr_cnt_o                      count of committed writes, wraps silently
module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              regwrite_i,
    input  logic              memtoreg_i,
    input  logic [DATA_W-1:0] readdata_i,
    input  logic [DATA_W-1:0] aluresult_i,
    input  logic [ADDR_W-1:0] rd_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [ADDR_W-1:0] wb_rd_o,
    output logic              wb_en_o,
    output logic [CNT_W-1:0]  wr_cnt_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic [DATA_W-1:0] wb_data;
    logic              wb_en;
    logic              rd_in_range;

    // Write-back selection and the effective enable. r0 is never a real
    // target, so the forwarding unit never sees a write to it either.
    always_comb begin
        wb_data     = memtoreg_i ? readdata_i : aluresult_i;
        rd_in_range = (int'(rd_i) < NUM_REGS);
        wb_en       = regwrite_i && (rd_i != '0) && rd_in_range;
    end

    assign wb_data_o = wb_data;
    assign wb_rd_o   = rd_i;
    assign wb_en_o   = wb_en;
    assign wr_cnt_o  = cnt_q;

    // Next state: at most one entry changes per cycle; the counter tracks
    // exactly the writes that land.
    always_comb begin
        regs_d = regs_q;
        cnt_d  = cnt_q;
        if (wb_en) begin
            regs_d[rd_i] = wb_data;
            cnt_d        = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            regs_q <= '{default: '0};
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
        end
    end

    // Read ports: r0 and out-of-range indices read zero; a write in flight
    // to the same index wins over the stored value so the ID stage sees the
    // result produced in this very cycle.
    always_comb begin
        rs_data_o = '0;
        if (rs_addr_i != '0 && int'(rs_addr_i) < NUM_REGS) begin
            if (wb_en && rd_i == rs_addr_i) begin
                rs_data_o = wb_data;
            end else begin
                rs_data_o = regs_q[rs_addr_i];
            end
        end
    end

    always_comb begin
        rt_data_o = '0;
        if (rt_addr_i != '0 && int'(rt_addr_i) < NUM_REGS) begin
            if (wb_en && rd_i == rt_addr_i) begin
                rt_data_o = wb_data;
            end else begin
                rt_data_o = regs_q[rt_addr_i];
            end
        end
    end

endmodule
